// File: rtl/core_pkg.sv
// core_pkg: shared encodings, widths and halt/dump FSM state type for the RV32I core
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    typedef enum logic [1:0] {RUN, DRAIN, EMIT, DONE} dump_state_t;
endpackage

// File: rtl/halt_dump_ctrl.sv
// halt_dump_ctrl: freezes fetch on EBREAK, drains the pipe, then streams {PC, x0..x(NREGS-1)}
module halt_dump_ctrl #(
    parameter int              XLEN         = core_pkg::XLEN,
    parameter logic [XLEN-1:0] HALT_INSTR   = core_pkg::EBREAK,
    parameter int              DRAIN_CYCLES = 5,
    parameter int              NREGS        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr_f,
    input  logic [XLEN-1:0] pc_f,
    input  logic            instr_valid_f,
    output logic            halt_o,
    output logic [XLEN-1:0] halt_pc,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [5:0]      dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            done
);
    import core_pkg::*;

    dump_state_t     state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            halt_d, valid_d, done_d;
    logic [XLEN-1:0] pc_d, data_d;
    logic [5:0]      idx_d;

    // The read port follows the beat index so the next register is ready at each transfer
    assign rf_raddr = state_q == EMIT ? dump_idx[4:0] : 5'd0;

    // Next-state and next-output computation; every register holds unless its state acts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        halt_d  = halt_o;
        pc_d    = halt_pc;
        valid_d = dump_valid;
        idx_d   = dump_idx;
        data_d  = dump_data;
        done_d  = done;
        case (state_q)
            RUN: if (instr_valid_f && instr_f == HALT_INSTR) begin
                halt_d  = 1'b1;
                pc_d    = pc_f;
                cnt_d   = 8'd0;
                state_d = DRAIN;
            end
            DRAIN: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(DRAIN_CYCLES - 1)) begin
                    valid_d = 1'b1;
                    idx_d   = 6'd0;
                    data_d  = halt_pc;
                    state_d = EMIT;
                end
            end
            EMIT: if (dump_valid && dump_ready) begin
                if (dump_idx == 6'(NREGS)) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d  = dump_idx + 6'd1;
                    data_d = rf_raddr == 5'd0 ? '0 : rf_rdata;
                end
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous reset back to RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            halt_o     <= 1'b0;
            halt_pc    <= '0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            halt_o     <= halt_d;
            halt_pc    <= pc_d;
            dump_valid <= valid_d;
            dump_idx   <= idx_d;
            dump_data  <= data_d;
            done       <= done_d;
        end
    end
endmodule

// File: tb/tb_halt_dump_ctrl.sv
// tb_halt_dump_ctrl: randomized halt/dump bench against a stream-level reference model
module tb_halt_dump_ctrl;
    localparam int DRAIN = 5;
    localparam int NBEATS = 33;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_f = '0;
    logic [31:0] pc_f = '0;
    logic        instr_valid_f = 1'b0;
    logic        halt_o;
    logic [31:0] halt_pc;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        dump_valid;
    logic        dump_ready = 1'b1;
    logic [5:0]  dump_idx;
    logic [31:0] dump_data;
    logic        done;

    logic [31:0] rf [32];
    assign rf_rdata = rf[rf_raddr];

    halt_dump_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .instr_f(instr_f), .pc_f(pc_f), .instr_valid_f(instr_valid_f),
        .halt_o(halt_o), .halt_pc(halt_pc), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: halt time, edges since halt, and beats accepted so far
    bit          m_halted = 0;
    logic [31:0] m_hpc = '0;
    int          m_k = 0;
    int          m_beats = 0;
    bit          m_valid = 0;

    function automatic logic [31:0] exp_data(input int b);
        return b == 0 ? m_hpc : b == 1 ? 32'd0 : rf[b-1];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_halted = 0;
            m_hpc = '0;
            m_k = 0;
            m_beats = 0;
        end else begin
            if (m_valid && dump_ready) m_beats++;
            if (m_halted) m_k++;
            else if (instr_valid_f && instr_f == EBREAK) begin
                m_halted = 1;
                m_hpc = pc_f;
                m_k = 0;
            end
        end
        m_valid = m_halted && m_k >= DRAIN && m_beats < NBEATS;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("halt_o", 32'(halt_o), 32'(m_halted));
            chk("halt_pc", halt_pc, m_halted ? m_hpc : 32'd0);
            chk("dump_valid", 32'(dump_valid), 32'(m_valid));
            chk("done", 32'(done), 32'(m_beats == NBEATS));
            chk("rf_raddr", 32'(rf_raddr), m_valid ? 32'(m_beats % 32) : 32'd0);
            if (m_valid) begin
                chk("dump_idx", 32'(dump_idx), 32'(m_beats));
                chk("dump_data", dump_data, exp_data(m_beats));
            end else if (!m_halted) begin
                chk("idle_idx", 32'(dump_idx), 32'd0);
                chk("idle_data", dump_data, 32'd0);
            end
        end
    end

    int          nbeats = 0;
    logic [31:0] beat_data [64];

    always @(negedge clk) begin
        if (rst) begin
            nbeats = 0;
            for (int i = 0; i < 64; i++) beat_data[i] = '0;
        end else if (dump_valid === 1'b1 && dump_ready) begin
            if (started) chk("beat_order", 32'(dump_idx), 32'(nbeats));
            beat_data[dump_idx] = dump_data;
            nbeats++;
        end
    end

    int ready_mode = 0;
    bit noise_en = 0;
    bit tog = 0;

    task automatic tick();
        int r;
        @(posedge clk);
        #2;
        tog = !tog;
        dump_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? tog : 1'($urandom_range(0, 1));
        if (noise_en) begin
            r = $urandom_range(0, 3);
            instr_f = r == 0 ? EBREAK : r == 1 ? ECALL : $urandom;
            pc_f = $urandom;
            instr_valid_f = 1'($urandom_range(0, 1));
            if (!m_halted && instr_valid_f && instr_f == EBREAK) instr_valid_f = 1'b0;
        end else begin
            instr_f = '0;
            instr_valid_f = 1'b0;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        instr_valid_f = 1'b0;
    endtask

    task automatic send_halt(input logic [31:0] pc);
        instr_f = EBREAK;
        pc_f = pc;
        instr_valid_f = 1'b1;
    endtask

    task automatic fill_rf();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit any;
        fill_rf();
        reset_dut();
        started = 1;
        chk("rst_halt_o", 32'(halt_o), 32'd0);
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // basic dump with repeat halts in DRAIN and DONE
        noise_en = 1;
        ready_mode = 0;
        tick();
        send_halt(32'h40);
        tick();
        chk("t1_halt_rise", 32'(halt_o), 32'd1);
        chk("t1_no_early_beat", 32'(dump_valid), 32'd0);
        send_halt(32'h44);
        n = 1;
        while (!dump_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t1_first_beat_cycle", 32'(n), 32'd6);
        chk("t1_first_idx", 32'(dump_idx), 32'd0);
        chk("t1_first_data", dump_data, 32'h40);
        wait_done(100, n);
        chk("t1_done_latency", 32'(n), 32'd33);
        chk("t1_beats", 32'(nbeats), 32'd33);
        tick();
        send_halt(32'h44);
        repeat (3) tick();
        chk("t6_halt_pc", halt_pc, 32'h40);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_beats", 32'(nbeats), 32'd33);

        // back-pressure with toggling ready
        reset_dut();
        ready_mode = 1;
        fill_rf();
        tick();
        send_halt(32'h40);
        wait_done(200, n);
        chk("t2_beats", 32'(nbeats), 32'd33);
        chk("t2_pc_beat", beat_data[0], 32'h40);
        chk("t2_last_beat", beat_data[32], rf[31]);

        // x0 forcing with random ready
        reset_dut();
        ready_mode = 2;
        fill_rf();
        rf[0] = 32'hDEAD_BEEF;
        rf[5] = 32'h0000_1234;
        tick();
        send_halt(32'h100);
        wait_done(300, n);
        chk("t3_x0", beat_data[1], 32'd0);
        chk("t3_x5", beat_data[6], 32'h0000_1234);
        chk("t3_beats", 32'(nbeats), 32'd33);

        // non-trigger encodings
        reset_dut();
        noise_en = 0;
        tick();
        instr_f = ECALL;
        instr_valid_f = 1'b1;
        tick();
        instr_f = EBREAK;
        instr_valid_f = 1'b0;
        any = 0;
        repeat (20) begin
            tick();
            any = any | halt_o | dump_valid;
        end
        chk("t4_no_halt", 32'(any), 32'd0);

        // reset in the middle of a dump, then re-halt
        noise_en = 1;
        ready_mode = 2;
        fill_rf();
        tick();
        send_halt(32'h40);
        n = 0;
        while (!(dump_valid && dump_idx == 6'd10) && n < 200) begin
            tick();
            n++;
        end
        chk("t5_reach_idx10", 32'(dump_idx), 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        instr_valid_f = 1'b0;
        chk("t5_halt_o", 32'(halt_o), 32'd0);
        chk("t5_halt_pc", halt_pc, 32'd0);
        chk("t5_raddr", 32'(rf_raddr), 32'd0);
        chk("t5_valid", 32'(dump_valid), 32'd0);
        chk("t5_idx", 32'(dump_idx), 32'd0);
        chk("t5_data", dump_data, 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        tick();
        send_halt(32'h80);
        wait_done(300, n);
        chk("t5_pc_beat", beat_data[0], 32'h80);
        chk("t5_beats", 32'(nbeats), 32'd33);
        chk("t5_halt_pc_new", halt_pc, 32'h80);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
